// File: rtl/angle_calc_scheduler.sv
// Arbitrates pan/tilt angle jobs onto one shared divider and arctan CORDIC.
// Ports: pan/tilt req+deltas in, acks out; divider and CORDIC handshakes;
// angle/angle_owner/angle_valid result; busy. ANGLE_SCHED_TIMEOUT_EN adds timeout.
module angle_calc_scheduler #(
  parameter int DELTA_W     = 10,
  parameter int PHASE_W     = 10,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pan_req,
  input  logic [DELTA_W-1:0] pan_dx,
  input  logic [DELTA_W-1:0] pan_dy,
  output logic               pan_ack,
  input  logic               tilt_req,
  input  logic [DELTA_W-1:0] tilt_dx,
  input  logic [DELTA_W-1:0] tilt_dy,
  output logic               tilt_ack,
  output logic               div_start,
  output logic [DELTA_W-2:0] div_dividend,
  output logic [DELTA_W-2:0] div_divisor,
  input  logic               div_ready,
  output logic               x_greater_than_y_del,
  output logic               cordic_nd,
  input  logic               cordic_rdy,
  input  logic [PHASE_W-1:0] cordic_phase,
  output logic               angle_valid,
  output logic               angle_owner,
  output logic [PHASE_W-1:0] angle,
  output logic               busy
`ifdef ANGLE_SCHED_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, DIV_WAIT, FMT, CORDIC_WAIT, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DELTA_W-1:0] dx_q, dx_d;
  logic [DELTA_W-1:0] dy_q, dy_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               xgt_q, xgt_d;
  logic [PHASE_W-1:0] angle_q, angle_d;
  logic [DELTA_W-2:0] mag_x, mag_y;
  logic               xge;
  logic               gnt_pan, gnt_tilt;

  // Most-negative input has no positive twin; clamp it to the max.
  function automatic logic [DELTA_W-2:0] mag(
    input logic [DELTA_W-1:0] v
  );
    logic [DELTA_W-1:0] n;
    n = -v;
    if (!v[DELTA_W-1])
      mag = v[DELTA_W-2:0];
    else if (v[DELTA_W-2:0] == '0)
      mag = '1;
    else
      mag = n[DELTA_W-2:0];
  endfunction

  assign mag_x = mag(dx_q);
  assign mag_y = mag(dy_q);
  assign xge   = (mag_x >= mag_y);

  assign div_dividend = xge ? mag_y : mag_x;
  assign div_divisor  = xge ? mag_x : mag_y;

  // last_q = 1 means tilt was granted last.
  assign gnt_pan  = pan_req & (~tilt_req | last_q);
  assign gnt_tilt = tilt_req & ~gnt_pan;

`ifdef ANGLE_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          expired;
  assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign timeout = to_q;
`endif

  always_comb begin
    state_d   = state_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    owner_d   = owner_q;
    last_d    = last_q;
    xgt_d     = xgt_q;
    angle_d   = angle_q;
    pan_ack   = 1'b0;
    tilt_ack  = 1'b0;
    div_start = 1'b0;
    cordic_nd = 1'b0;
`ifdef ANGLE_SCHED_TIMEOUT_EN
    cnt_d = cnt_q + CW'(1);
    to_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_pan: begin
            pan_ack = 1'b1;
            dx_d    = pan_dx;
            dy_d    = pan_dy;
            owner_d = 1'b0;
            last_d  = 1'b0;
            state_d = ISSUE;
          end
          gnt_tilt: begin
            tilt_ack = 1'b1;
            dx_d     = tilt_dx;
            dy_d     = tilt_dy;
            owner_d  = 1'b1;
            last_d   = 1'b1;
            state_d  = ISSUE;
          end
          default: ;
        endcase
      end
      ISSUE: begin
        xgt_d = xge;
        if (mag_x == '0 && mag_y == '0) begin
          angle_d = '0;
          state_d = DONE;
        end else begin
          div_start = 1'b1;
          state_d   = DIV_WAIT;
`ifdef ANGLE_SCHED_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      DIV_WAIT: begin
        if (div_ready) begin
          state_d = FMT;
`ifdef ANGLE_SCHED_TIMEOUT_EN
        end else if (expired) begin
          angle_d = '0;
          to_d    = 1'b1;
          state_d = DONE;
`endif
        end
      end
      FMT: begin
        cordic_nd = 1'b1;
        state_d   = CORDIC_WAIT;
`ifdef ANGLE_SCHED_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      CORDIC_WAIT: begin
        if (cordic_rdy) begin
          angle_d = cordic_phase;
          state_d = DONE;
`ifdef ANGLE_SCHED_TIMEOUT_EN
        end else if (expired) begin
          angle_d = '0;
          to_d    = 1'b1;
          state_d = DONE;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      xgt_q   <= 1'b0;
      angle_q <= '0;
`ifdef ANGLE_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      xgt_q   <= xgt_d;
      angle_q <= angle_d;
`ifdef ANGLE_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign x_greater_than_y_del = xgt_q;
  assign angle_valid          = (state_q == DONE);
  assign angle_owner          = owner_q;
  assign angle                = angle_q;
  assign busy                 = (state_q != IDLE);

endmodule
